store_cntrl: RTL and testbench



---
 rtl/store_cntrl_pkg.sv | 42 ++++
 rtl/store_buf.sv | 54 +++++
 rtl/store_cntrl.sv | 64 ++++++
 tb/tb_store_cntrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_cntrl_pkg.sv
// core: memory-op encodings, pipeline bus, store-buffer entry and lane helper
// Shared by store_cntrl and store_buf; mem_op MSB selects load/store class.
package core;
   localparam int MEM_OP_BITS = 4;
   localparam logic LOAD_PRFX = 1'b0;
   localparam logic STORE_PRFX = 1'b1;
   typedef enum logic [MEM_OP_BITS-1:0] {
      MEM_NOP = 4'b0000,
      MEM_LB  = 4'b0001,
      MEM_LH  = 4'b0010,
      MEM_LW  = 4'b0011,
      MEM_LBU = 4'b0100,
      MEM_LHU = 4'b0101,
      MEM_SB  = 4'b1000,
      MEM_SH  = 4'b1001,
      MEM_SW  = 4'b1010
   } mem_op_t;
   typedef struct packed {
      mem_op_t     mem_op;
      logic [31:0] rs1_data;
      logic [31:0] imm;
      logic [31:0] rs2_data;
      logic        pipeline_stall;
   } pipeline_bus_t;
   typedef struct packed {
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } st_entry_t;
   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        misaligned;
   } st_lanes_t;
   function automatic st_lanes_t st_lanes(input mem_op_t mem_op, input logic [1:0] off, input logic [31:0] rs2_data);
      st_lanes_t r;
      r.be = mem_op == MEM_SB ? 4'b0001 << off : mem_op == MEM_SH ? 4'b0011 << off : 4'b1111;
      r.wdata = mem_op == MEM_SB ? {4{rs2_data[7:0]}} : mem_op == MEM_SH ? {2{rs2_data[15:0]}} : rs2_data;
      r.misaligned = mem_op == MEM_SB ? 1'b0 : mem_op == MEM_SH ? off[0] : off != 2'b00;
      return r;
   endfunction
endpackage

// File: rtl/store_buf.sv
// store_buf: in-order FIFO of store entries with per-slot valid/address taps
// Ports: push/din enqueue, pop retires head, full/empty status,
// valid/addr_vec expose every slot (30-bit word address each) for hazard compare.
module store_buf
   import core::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push,
   input  logic                pop,
   input  st_entry_t           din,
   output st_entry_t           head,
   output logic                full,
   output logic                empty,
   output logic [DEPTH-1:0]    valid,
   output logic [DEPTH*30-1:0] addr_vec
);
   st_entry_t mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0] count;
   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // pop clears before push sets, so a full-buffer push/pop on the same slot stays valid
         if (pop) begin
            rd_ptr <= nxt(rd_ptr);
            valid[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr <= nxt(wr_ptr);
            valid[wr_ptr] <= 1'b1;
            mem[wr_ptr] <= din;
         end
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end
   assign head = mem[rd_ptr];
   assign full = count == (PTR_W + 1)'(DEPTH);
   assign empty = count == '0;
   for (genvar g = 0; g < DEPTH; g++) begin : g_tap
      assign addr_vec[g*30 +: 30] = mem[g].addr;
   end
endmodule

// File: rtl/store_cntrl.sv
// store_cntrl: MEM-stage store path - lane formatting, store buffer, req/gnt drain
// Ports: bus_i pipeline bus in; mem_* write request/handshake to data memory;
// st_stall_o full-buffer stall, misalign_o dropped-store pulse,
// ld_hazard_o load hits a pending store word, empty_o buffer drained.
module store_cntrl
   import core::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  pipeline_bus_t bus_i,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [31:0]   mem_addr_o,
   output logic [3:0]    mem_be_o,
   output logic [31:0]   mem_wdata_o,
   input  logic          mem_gnt_i,
   output logic          st_stall_o,
   output logic          misalign_o,
   output logic          ld_hazard_o,
   output logic          empty_o
);
   logic [MEM_OP_BITS-1:0] op;
   logic [31:0] addr;
   st_lanes_t lanes;
   st_entry_t head;
   logic is_st, is_ld, ok_st, push, pop, full, empty;
   logic [DEPTH-1:0] valid, hit;
   logic [DEPTH*30-1:0] addr_vec;
   assign op = bus_i.mem_op;
   assign addr = bus_i.rs1_data + bus_i.imm;
   assign lanes = st_lanes(bus_i.mem_op, addr[1:0], bus_i.rs2_data);
   assign is_st = op != MEM_NOP && op[MEM_OP_BITS-1] == STORE_PRFX && !bus_i.pipeline_stall;
   assign is_ld = op != MEM_NOP && op[MEM_OP_BITS-1] == LOAD_PRFX;
   assign ok_st = is_st && !lanes.misaligned;
   assign pop = mem_req_o && mem_gnt_i;
   // a retiring head frees a slot in the same cycle, so a full buffer can still accept
   assign push = ok_st && (!full || pop);
   assign st_stall_o = ok_st && full && !pop;
   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      assign hit[g] = valid[g] && addr_vec[g*30 +: 30] == addr[31:2];
   end
   assign ld_hazard_o = is_ld && |hit;
   assign mem_req_o = !empty;
   assign mem_we_o = mem_req_o;
   assign mem_addr_o = {head.addr, 2'b00};
   assign mem_be_o = head.be;
   assign mem_wdata_o = head.wdata;
   assign empty_o = empty;
   always_ff @(posedge clk_i) misalign_o <= rst_i ? 1'b0 : is_st && lanes.misaligned;
   store_buf #(.DEPTH(DEPTH)) u_buf (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (push),
      .pop      (pop),
      .din      ({addr[31:2], lanes.be, lanes.wdata}),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .valid    (valid),
      .addr_vec (addr_vec)
   );
endmodule

// File: tb/tb_store_cntrl.sv
// tb_store_cntrl: directed stimulus with a drain scoreboard for store_cntrl
module tb_store_cntrl;
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } txn_t;
   logic clk = 1'b0;
   logic rst;
   core::pipeline_bus_t bus;
   logic mem_req, mem_we, mem_gnt, st_stall, misalign, ld_hazard, empty;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0] mem_be;
   txn_t exp_q[$];
   txn_t e;
   int checks = 0;
   int errors = 0;
   store_cntrl #(.DEPTH(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus_i       (bus),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_be_o    (mem_be),
      .mem_wdata_o (mem_wdata),
      .mem_gnt_i   (mem_gnt),
      .st_stall_o  (st_stall),
      .misalign_o  (misalign),
      .ld_hazard_o (ld_hazard),
      .empty_o     (empty)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, req);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus = '0;
      bus.mem_op = core::MEM_NOP;
   endtask
   task automatic op(input core::mem_op_t o, input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2);
      bus = '0;
      bus.mem_op = o;
      bus.rs1_data = rs1;
      bus.imm = imm;
      bus.rs2_data = rs2;
   endtask
   task automatic expect_txn(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      exp_q.push_back('{addr: a, be: b, wdata: d});
   endtask
   // scoreboard: every accepted request must match the oldest expected store
   always @(negedge clk) begin
      if (!rst && mem_req && mem_gnt) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req got addr=%h expected no request", mem_addr);
         end else begin
            e = exp_q.pop_front();
            chk("drain_addr", mem_addr, e.addr);
            chk("drain_be", {28'd0, mem_be}, {28'd0, e.be});
            chk("drain_wdata", mem_wdata, e.wdata);
            chk("drain_we", {31'd0, mem_we}, 32'd1);
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      mem_gnt = 1'b0;
      idle();
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req", {31'd0, mem_req}, 0);
      chk("rst_we", {31'd0, mem_we}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", {28'd0, mem_be}, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_misalign", {31'd0, misalign}, 0);
      chk("rst_empty", {31'd0, empty}, 1);
      chk("rst_stall", {31'd0, st_stall}, 0);
      chk("rst_hazard", {31'd0, ld_hazard}, 0);
      // byte store
      step();
      op(core::MEM_SB, 32'h1000, 32'd3, 32'hAB);
      expect_txn(32'h1000, 4'b1000, 32'hABABABAB);
      step();
      idle();
      @(negedge clk);
      chk("sb_req", {31'd0, mem_req}, 1);
      chk("sb_addr", mem_addr, 32'h1000);
      chk("sb_be", {28'd0, mem_be}, 32'h8);
      chk("sb_wdata", mem_wdata, 32'hABABABAB);
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("sb_empty", {31'd0, empty}, 1);
      // half + word back-to-back with gnt held high
      step();
      mem_gnt = 1'b1;
      op(core::MEM_SH, 32'h2000, 32'd2, 32'h1234BEEF);
      expect_txn(32'h2000, 4'b1100, 32'hBEEFBEEF);
      step();
      op(core::MEM_SW, 32'h3000, 32'd0, 32'hDEADBEEF);
      expect_txn(32'h3000, 4'b1111, 32'hDEADBEEF);
      step();
      idle();
      repeat (2) step();
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("shsw_empty", {31'd0, empty}, 1);
      // address wrap-around: 0 + 0xFFFFFFFF
      step();
      op(core::MEM_SB, 32'h0, 32'hFFFFFFFF, 32'h5A);
      expect_txn(32'hFFFFFFFC, 4'b1000, 32'h5A5A5A5A);
      step();
      idle();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      // misaligned SW and SH
      op(core::MEM_SW, 32'h1000, 32'd1, 32'h11111111);
      @(negedge clk);
      chk("mis_sw_stall", {31'd0, st_stall}, 0);
      step();
      idle();
      @(negedge clk);
      chk("mis_sw_pulse", {31'd0, misalign}, 1);
      chk("mis_sw_req", {31'd0, mem_req}, 0);
      chk("mis_sw_empty", {31'd0, empty}, 1);
      step();
      op(core::MEM_SH, 32'h1003, 32'd0, 32'h2222);
      @(negedge clk);
      chk("mis_sw_pulse_end", {31'd0, misalign}, 0);
      step();
      idle();
      @(negedge clk);
      chk("mis_sh_pulse", {31'd0, misalign}, 1);
      chk("mis_sh_empty", {31'd0, empty}, 1);
      step();
      @(negedge clk);
      chk("mis_sh_pulse_end", {31'd0, misalign}, 0);
      chk("mis_sh_req", {31'd0, mem_req}, 0);
      // full buffer: A, B queued, C stalls until a grant frees a slot
      step();
      op(core::MEM_SW, 32'h5000, 32'd0, 32'hA);
      expect_txn(32'h5000, 4'hF, 32'hA);
      step();
      op(core::MEM_SW, 32'h5004, 32'd0, 32'hB);
      expect_txn(32'h5004, 4'hF, 32'hB);
      step();
      op(core::MEM_SW, 32'h5008, 32'd0, 32'hC);
      expect_txn(32'h5008, 4'hF, 32'hC);
      @(negedge clk);
      chk("full_stall", {31'd0, st_stall}, 1);
      step();
      @(negedge clk);
      chk("full_stall_hold", {31'd0, st_stall}, 1);
      chk("full_head_a", mem_addr, 32'h5000);
      step();
      mem_gnt = 1'b1;
      @(negedge clk);
      chk("full_stall_drop", {31'd0, st_stall}, 0);
      step();
      idle();
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("full_head_b", mem_addr, 32'h5004);
      chk("full_no_stall", {31'd0, st_stall}, 0);
      step();
      mem_gnt = 1'b1;
      repeat (2) step();
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("full_drained", {31'd0, empty}, 1);
      // load-after-store hazard
      step();
      op(core::MEM_SW, 32'h4000, 32'd0, 32'h1);
      expect_txn(32'h4000, 4'hF, 32'h1);
      step();
      op(core::MEM_LW, 32'h4000, 32'd2, 32'h0);
      @(negedge clk);
      chk("haz_hit", {31'd0, ld_hazard}, 1);
      step();
      op(core::MEM_LW, 32'h4000, 32'd4, 32'h0);
      @(negedge clk);
      chk("haz_other_word", {31'd0, ld_hazard}, 0);
      step();
      op(core::MEM_LW, 32'h4000, 32'd2, 32'h0);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("haz_cleared", {31'd0, ld_hazard}, 0);
      chk("haz_empty", {31'd0, empty}, 1);
      // reset with two pending entries
      step();
      op(core::MEM_SW, 32'h6000, 32'd0, 32'h6);
      expect_txn(32'h6000, 4'hF, 32'h6);
      step();
      op(core::MEM_SW, 32'h6004, 32'd0, 32'h7);
      expect_txn(32'h6004, 4'hF, 32'h7);
      step();
      idle();
      @(negedge clk);
      chk("pre_rst_req", {31'd0, mem_req}, 1);
      step();
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_req", {31'd0, mem_req}, 0);
      chk("mid_rst_empty", {31'd0, empty}, 1);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_be", {28'd0, mem_be}, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      step();
      mem_gnt = 1'b1;
      repeat (3) step();
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("mid_rst_no_req", {31'd0, mem_req}, 0);
      chk("scoreboard_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
